// File: rtl/alu_pkg.sv
// Shared types and constants for the accumulator sequencer and its arbiter.
package alu_pkg;
  localparam int ACC_W = 8;
  localparam int N_REQ = 2;
  // Most negative accumulator value; its negation does not fit in ACC_W bits.
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the favoured requester on a tie.
module rr_arb2
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic             owner,
  output logic [N_REQ-1:0] gnt_next,
  output logic             ptr
);

  logic r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (advance) begin
      r_ptr <= ~owner;
    end
  end

  always_comb begin
    gnt_next = req;
    if (&req) begin
      gnt_next = r_ptr ? 2'b10 : 2'b01;
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/acc_sequencer.sv
// Shares an external s <= s + in accumulator between two requesters, one job at a time.
//   state   | meaning
//   S_IDLE  | accumulator held, waiting for a request
//   S_CLEAR | driving the accumulator towards zero
//   S_RUN   | streaming owner operands into the accumulator
//   S_DONE  | result presented until consumed
module acc_sequencer
  import alu_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  output logic [1:0]   gnt,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [W-1:0] op_data,
  input  logic         op_last,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_ovf,
  output logic         res_id,
  output logic [W-1:0] acc_in,
  input  logic [W-1:0] acc_s
);

  state_t       r_state;
  state_t       w_next;
  logic [1:0]   r_gnt;
  logic         r_owner;
  logic         r_ovf;
  logic [1:0]   w_gnt_next;
  logic         w_ptr;
  logic         w_accept;
  logic         w_advance;
  logic [W-1:0] w_sum;
  logic         w_beat_ovf;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .advance  (w_advance),
    .owner    (r_owner),
    .gnt_next (w_gnt_next),
    .ptr      (w_ptr)
  );

  assign w_sum      = acc_s + op_data;
  assign w_beat_ovf = (acc_s[W-1] == op_data[W-1]) && (w_sum[W-1] != acc_s[W-1]);

  always_comb begin
    w_next    = r_state;
    acc_in    = '0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    w_accept  = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        if (acc_s == '0) begin
          w_next = S_RUN;
        end else if (acc_s == ACC_MIN) begin
          // +MAX takes MIN to -1, which the next cycle negates normally.
          acc_in = {1'b0, {(W-1){1'b1}}};
        end else begin
          acc_in = -acc_s;
        end
      end
      S_RUN: begin
        op_ready = 1'b1;
        if (op_valid) begin
          acc_in   = op_data;
          w_accept = 1'b1;
          if (op_last) w_next = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_advance = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= 2'b00;
      r_owner <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && (|req)) begin
        r_gnt   <= w_gnt_next;
        r_owner <= (&req) ? w_ptr : req[1];
      end
      if (w_accept) r_ovf <= r_ovf | w_beat_ovf;
      if (w_advance) begin
        r_gnt <= 2'b00;
        r_ovf <= 1'b0;
      end
    end
  end

  assign gnt      = r_gnt;
  assign res_data = (r_state == S_DONE) ? acc_s : '0;
  assign res_ovf  = (r_state == S_DONE) && r_ovf;
  assign res_id   = r_owner;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer with a behavioural s <= s + in accumulator.
module tb_acc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] gnt;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [7:0] op_data = 8'd0;
  logic       op_last = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_ovf;
  logic       res_id;
  logic [7:0] acc_in;
  logic [7:0] acc_m;

  int total = 0;
  int bad   = 0;

  acc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_data   (op_data),
    .op_last   (op_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .res_id    (res_id),
    .acc_in    (acc_in),
    .acc_s     (acc_m)
  );

  always #5 clk = ~clk;

  always @(posedge clk) acc_m <= acc_m + acc_in;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  task automatic stream_and_finish(input int n, input int o0, input int o1, input int o2,
                                   input int o3, input int exp_data, input int exp_ovf,
                                   input int exp_id, input int hold);
    int ops[4];
    int k;
    ops = '{o0, o1, o2, o3};
    k = 0;
    while (!op_ready && k < 6) begin
      tick();
      k++;
    end
    chk("op_ready_wait", int'(op_ready), 1);
    for (int i = 0; i < n; i++) begin
      op_valid = 1'b1;
      op_data  = 8'(ops[i]);
      op_last  = (i == n - 1);
      tick();
    end
    op_valid = 1'b0;
    op_last  = 1'b0;
    chk("res_valid", int'(res_valid), 1);
    chk("res_data", sx(res_data), exp_data);
    chk("res_ovf", int'(res_ovf), exp_ovf);
    chk("res_id", int'(res_id), exp_id);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", int'(res_valid), 1);
      chk("hold_data", sx(res_data), exp_data);
      chk("hold_ready", int'(op_ready), 0);
      chk("hold_acc_in", sx(acc_in), 0);
      chk("hold_acc_s", sx(acc_m), exp_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_dropped", int'(res_valid), 0);
  endtask

  task automatic do_job(input logic [1:0] rq, input int exp_gnt, input int n, input int o0,
                        input int o1, input int o2, input int o3, input int exp_data,
                        input int exp_ovf, input int exp_id, input int hold);
    int k;
    req = rq;
    k = 0;
    while (gnt == 2'b00 && k < 10) begin
      tick();
      k++;
    end
    chk("gnt", int'(gnt), exp_gnt);
    if (rq != 2'b11) req = 2'b00;
    stream_and_finish(n, o0, o1, o2, o3, exp_data, exp_ovf, exp_id, hold);
  endtask

  initial begin
    tick();
    tick();
    tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_ready", int'(op_ready), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_ovf", int'(res_ovf), 0);
    chk("rst_id", int'(res_id), 0);
    chk("rst_acc_in", sx(acc_in), 0);

    // Stale 37 after reset: one clearing cycle of -37.
    rst   = 1'b0;
    acc_m = 8'd37;
    req   = 2'b01;
    tick();
    chk("t1_gnt", int'(gnt), 1);
    chk("t1_clr", sx(acc_in), -37);
    chk("t1_clr_rdy", int'(op_ready), 0);
    req = 2'b00;
    tick();
    chk("t1_zero_in", sx(acc_in), 0);
    chk("t1_zero_rdy", int'(op_ready), 0);
    stream_and_finish(2, 10, 20, 0, 0, 30, 0, 0, 0);

    // Stale -128: +127, then +1, RUN on the third cycle after gnt; overflow job.
    acc_m = 8'h80;
    req   = 2'b10;
    tick();
    chk("t2_gnt", int'(gnt), 2);
    chk("t2_in127", sx(acc_in), 127);
    req = 2'b00;
    tick();
    chk("t2_in1", sx(acc_in), 1);
    tick();
    chk("t2_c3_rdy", int'(op_ready), 0);
    tick();
    chk("t2_run_rdy", int'(op_ready), 1);
    stream_and_finish(4, 10, 20, 127, -50, 107, 1, 1, 0);
    do_job(2'b01, 1, 1, 5, 0, 0, 0, 5, 0, 0, 0);

    // Result held while res_ready stays low.
    do_job(2'b10, 2, 1, -7, 0, 0, 0, -7, 0, 1, 3);

    // Both requesting from reset: 01, 10, 01.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_job(2'b11, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    do_job(2'b11, 2, 1, 1, 0, 0, 0, 1, 0, 1, 0);
    do_job(2'b11, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    req = 2'b00;
    tick();

    // Reset mid-RUN, then a fresh job.
    req = 2'b01;
    begin
      int k;
      k = 0;
      while (!op_ready && k < 10) begin
        tick();
        k++;
      end
    end
    req      = 2'b00;
    op_valid = 1'b1;
    op_data  = 8'd10;
    tick();
    op_data = 8'd20;
    tick();
    op_valid = 1'b0;
    rst      = 1'b1;
    tick();
    chk("t6_gnt", int'(gnt), 0);
    chk("t6_ready", int'(op_ready), 0);
    chk("t6_valid", int'(res_valid), 0);
    rst = 1'b0;
    do_job(2'b01, 1, 1, 3, 0, 0, 0, 3, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
